// File: rtl/sauria_cfg_readback.sv
// ============================================================================
//  Module   : sauria_cfg_readback
//  Streams a snapshot of a packed configuration vector out as 32-bit words,
//  LSB word first, over a valid/ready port.
//  Optional : SAURIA_CFG_RB_PARITY_EN adds per-word parity and a running XOR.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sauria_cfg_readback #(
  parameter  int CFG_BITS = 150,
  parameter  int WORD_W   = 32,
  localparam int N_WORDS  = (CFG_BITS + WORD_W - 1) / WORD_W,
  localparam int IDX_W    = (N_WORDS > 1) ? $clog2(N_WORDS) : 1
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic [CFG_BITS-1:0] i_cfg,
  input  logic                i_start,
  output logic                o_busy,
  output logic [WORD_W-1:0]   o_data,
  output logic [IDX_W-1:0]    o_idx,
  output logic                o_valid,
  input  logic                i_ready,
  output logic                o_last,
  output logic                o_done
`ifdef SAURIA_CFG_RB_PARITY_EN
  ,
  output logic                o_parity,
  output logic [WORD_W-1:0]   o_chk
`endif
);

  localparam int              c_PAD      = N_WORDS * WORD_W - CFG_BITS;
  localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(N_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                     r_state;
  logic [CFG_BITS-1:0]        r_shadow;
  logic [IDX_W-1:0]           r_idx;
  logic [WORD_W-1:0]          r_data;
  logic                       r_valid;
  logic                       r_busy;
  logic                       r_last;
  logic                       r_done;

  logic [N_WORDS*WORD_W-1:0]  w_shd_pad;
  logic [WORD_W-1:0]          w_shd_words [N_WORDS];
  logic [WORD_W-1:0]          w_cfg_w0;
  logic                       w_accept;
  logic                       w_xfer;
  logic                       w_is_last;
  logic [IDX_W-1:0]           w_next_idx;
  logic [WORD_W-1:0]          w_next_data;

  // The final word is zero-extended above CFG_BITS.
  generate
    if (c_PAD > 0) begin : g_pad
      assign w_shd_pad = {{c_PAD{1'b0}}, r_shadow};
    end else begin : g_nopad
      assign w_shd_pad = r_shadow;
    end

    if (CFG_BITS >= WORD_W) begin : g_w0_full
      assign w_cfg_w0 = i_cfg[WORD_W-1:0];
    end else begin : g_w0_short
      assign w_cfg_w0 = {{(WORD_W - CFG_BITS){1'b0}}, i_cfg};
    end

    for (genvar k = 0; k < N_WORDS; k++) begin : g_words
      assign w_shd_words[k] = w_shd_pad[k*WORD_W +: WORD_W];
    end
  endgenerate

  assign w_accept    = (r_state == S_IDLE) && i_start;
  assign w_xfer      = r_valid && i_ready;
  assign w_is_last   = (r_idx == c_LAST_IDX);
  // Saturating next index keeps the word lookup in range on the last word.
  assign w_next_idx  = w_is_last ? r_idx : r_idx + 1'b1;
  assign w_next_data = w_shd_words[w_next_idx];

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state  <= S_IDLE;
      r_shadow <= '0;
      r_idx    <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_last   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_shadow <= i_cfg;
            r_idx    <= '0;
            r_data   <= w_cfg_w0;
            r_valid  <= 1'b1;
            r_busy   <= 1'b1;
            r_last   <= (N_WORDS == 1);
            r_state  <= S_SEND;
          end
        end
        S_SEND: begin
          if (w_xfer) begin
            if (w_is_last) begin
              r_idx   <= '0;
              r_data  <= '0;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_last  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_idx  <= w_next_idx;
              r_data <= w_next_data;
              r_last <= (w_next_idx == c_LAST_IDX);
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_last  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy  = r_busy;
  assign o_data  = r_data;
  assign o_idx   = r_idx;
  assign o_valid = r_valid;
  assign o_last  = r_last;
  assign o_done  = r_done;

`ifdef SAURIA_CFG_RB_PARITY_EN
  logic              r_parity;
  logic [WORD_W-1:0] r_chk;

  // Parity tracks r_data; the checksum folds in each word as it is accepted.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_parity <= 1'b0;
      r_chk    <= '0;
    end else if (w_accept) begin
      r_parity <= ^w_cfg_w0;
      r_chk    <= '0;
    end else if ((r_state == S_SEND) && w_xfer) begin
      r_parity <= w_is_last ? 1'b0 : ^w_next_data;
      r_chk    <= r_chk ^ r_data;
    end
  end

  assign o_parity = r_parity;
  assign o_chk    = r_chk;
`else
  logic w_unused_accept;
  assign w_unused_accept = w_accept;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sauria_cfg_readback.sv
// ============================================================================
//  Module   : tb_sauria_cfg_readback
//  Self-checking bench for sauria_cfg_readback (CFG_BITS=150, 5 words).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sauria_cfg_readback;

  localparam int CFG_BITS = 150;

  logic                clk = 1'b0;
  logic                rstn;
  logic [CFG_BITS-1:0] cfg;
  logic                start;
  logic                ready;
  logic                busy;
  logic [31:0]         data;
  logic [2:0]          idx;
  logic                valid;
  logic                last;
  logic                done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

`ifdef SAURIA_CFG_RB_PARITY_EN
  logic        par_m;
  logic [31:0] chk_m;
  logic [63:0] cfg64;
  logic        start64;
  logic        ready64;
  logic        busy64;
  logic [31:0] data64;
  logic [0:0]  idx64;
  logic        valid64;
  logic        last64;
  logic        done64;
  logic        par64;
  logic [31:0] chk64;

  sauria_cfg_readback #(.CFG_BITS(CFG_BITS)) u_dut (
    .i_clk(clk), .i_rstn(rstn), .i_cfg(cfg), .i_start(start), .o_busy(busy),
    .o_data(data), .o_idx(idx), .o_valid(valid), .i_ready(ready), .o_last(last),
    .o_done(done), .o_parity(par_m), .o_chk(chk_m));

  sauria_cfg_readback #(.CFG_BITS(64)) u_dut64 (
    .i_clk(clk), .i_rstn(rstn), .i_cfg(cfg64), .i_start(start64), .o_busy(busy64),
    .o_data(data64), .o_idx(idx64), .o_valid(valid64), .i_ready(ready64),
    .o_last(last64), .o_done(done64), .o_parity(par64), .o_chk(chk64));
`else
  sauria_cfg_readback #(.CFG_BITS(CFG_BITS)) u_dut (
    .i_clk(clk), .i_rstn(rstn), .i_cfg(cfg), .i_start(start), .o_busy(busy),
    .o_data(data), .o_idx(idx), .o_valid(valid), .i_ready(ready), .o_last(last),
    .o_done(done));
`endif

  typedef struct {
    logic                start;
    logic                ready;
    logic [CFG_BITS-1:0] cfg;
    logic                valid;
    logic [2:0]          idx;
    logic                last;
    logic                done;
    logic                busy;
    logic [31:0]         data;
  } vec_t;

  vec_t vt[23];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic s, input logic r, input logic [CFG_BITS-1:0] c,
                              input logic v, input logic [2:0] i, input logic l,
                              input logic d, input logic b, input logic [31:0] w);
    vec_t t;
    t.start = s; t.ready = r; t.cfg = c; t.valid = v; t.idx = i;
    t.last = l; t.done = d; t.busy = b; t.data = w;
    return t;
  endfunction

  logic [151:0]        a5_full;
  logic [CFG_BITS-1:0] cfg_a5;
  logic [CFG_BITS-1:0] cfg_b;
  logic [CFG_BITS-1:0] cfg_ones;

  initial begin
    a5_full  = {19{8'hA5}};
    cfg_a5   = a5_full[CFG_BITS-1:0];
    cfg_b    = {22'h2ABCDE, 32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    cfg_ones = '1;

    // Transfer A: full-rate, done pulse on the 7th cycle counting the start cycle
    vt[0]  = mk(1, 1, cfg_a5,   1, 0, 0, 0, 1, 32'hA5A5A5A5);
    vt[1]  = mk(0, 1, cfg_a5,   1, 1, 0, 0, 1, 32'hA5A5A5A5);
    vt[2]  = mk(0, 1, cfg_a5,   1, 2, 0, 0, 1, 32'hA5A5A5A5);
    vt[3]  = mk(0, 1, cfg_a5,   1, 3, 0, 0, 1, 32'hA5A5A5A5);
    vt[4]  = mk(0, 1, cfg_a5,   1, 4, 1, 0, 1, 32'h0025A5A5);
    vt[5]  = mk(0, 1, cfg_a5,   0, 0, 0, 1, 0, 32'h0);
    vt[6]  = mk(0, 1, cfg_a5,   0, 0, 0, 0, 0, 32'h0);
    // Transfer B: backpressure, cfg overwritten after start, start in SEND and DONE
    vt[7]  = mk(1, 1, cfg_b,    1, 0, 0, 0, 1, 32'h11111111);
    vt[8]  = mk(0, 1, cfg_ones, 1, 1, 0, 0, 1, 32'h22222222);
    vt[9]  = mk(0, 0, cfg_ones, 1, 1, 0, 0, 1, 32'h22222222);
    vt[10] = mk(0, 0, cfg_ones, 1, 1, 0, 0, 1, 32'h22222222);
    vt[11] = mk(0, 1, cfg_ones, 1, 2, 0, 0, 1, 32'h33333333);
    vt[12] = mk(1, 0, cfg_ones, 1, 2, 0, 0, 1, 32'h33333333);
    vt[13] = mk(0, 0, cfg_ones, 1, 2, 0, 0, 1, 32'h33333333);
    vt[14] = mk(0, 1, cfg_ones, 1, 3, 0, 0, 1, 32'h44444444);
    vt[15] = mk(0, 0, cfg_ones, 1, 3, 0, 0, 1, 32'h44444444);
    vt[16] = mk(0, 0, cfg_ones, 1, 3, 0, 0, 1, 32'h44444444);
    vt[17] = mk(0, 1, cfg_ones, 1, 4, 1, 0, 1, 32'h002ABCDE);
    vt[18] = mk(0, 0, cfg_ones, 1, 4, 1, 0, 1, 32'h002ABCDE);
    vt[19] = mk(0, 0, cfg_ones, 1, 4, 1, 0, 1, 32'h002ABCDE);
    vt[20] = mk(0, 1, cfg_ones, 0, 0, 0, 1, 0, 32'h0);
    vt[21] = mk(1, 1, cfg_ones, 0, 0, 0, 0, 0, 32'h0);
    vt[22] = mk(0, 1, cfg_ones, 0, 0, 0, 0, 0, 32'h0);

    rstn  = 1'b0;
    start = 1'b0;
    ready = 1'b0;
    cfg   = cfg_a5;
`ifdef SAURIA_CFG_RB_PARITY_EN
    cfg64   = 64'h1;
    start64 = 1'b0;
    ready64 = 1'b0;
`endif
    tick();
    tick();
    check("rst_valid", {63'd0, valid}, 64'd0);
    check("rst_busy",  {63'd0, busy},  64'd0);
    check("rst_done",  {63'd0, done},  64'd0);
    check("rst_last",  {63'd0, last},  64'd0);
    check("rst_data",  {32'd0, data},  64'd0);
    check("rst_idx",   {61'd0, idx},   64'd0);
    rstn = 1'b1;
    tick();

    for (int i = 0; i < 23; i++) begin
      start = vt[i].start;
      ready = vt[i].ready;
      cfg   = vt[i].cfg;
      tick();
      check($sformatf("vec%0d_valid", i), {63'd0, valid}, {63'd0, vt[i].valid});
      check($sformatf("vec%0d_done", i),  {63'd0, done},  {63'd0, vt[i].done});
      check($sformatf("vec%0d_busy", i),  {63'd0, busy},  {63'd0, vt[i].busy});
      if (vt[i].valid) begin
        check($sformatf("vec%0d_idx", i),  {61'd0, idx},  {61'd0, vt[i].idx});
        check($sformatf("vec%0d_last", i), {63'd0, last}, {63'd0, vt[i].last});
        check($sformatf("vec%0d_data", i), {32'd0, data}, {32'd0, vt[i].data});
      end
    end

    // Level start: a new transfer begins right after DONE with the then-current cfg
    ready = 1'b1;
    cfg   = cfg_a5;
    start = 1'b1;
    tick();
    check("lvl_first_idx", {61'd0, idx}, 64'd0);
    cfg = cfg_b;
    for (int k = 0; k < 5; k++) tick();
    check("lvl_done", {63'd0, done}, 64'd1);
    tick();
    check("lvl_idle_valid", {63'd0, valid}, 64'd0);
    tick();
    check("lvl_restart_valid", {63'd0, valid}, 64'd1);
    check("lvl_restart_idx",   {61'd0, idx},   64'd0);
    check("lvl_restart_data",  {32'd0, data},  {32'd0, 32'h11111111});
    start = 1'b0;

    // Asynchronous reset in the middle of word 3
    tick();
    tick();
    tick();
    check("mid_idx3", {61'd0, idx}, 64'd3);
    #3;
    rstn = 1'b0;
    #1;
    check("arst_valid", {63'd0, valid}, 64'd0);
    check("arst_busy",  {63'd0, busy},  64'd0);
    check("arst_data",  {32'd0, data},  64'd0);
    tick();
    check("arst_no_done", {63'd0, done}, 64'd0);
    rstn = 1'b1;
    tick();
    check("post_rst_done", {63'd0, done}, 64'd0);
    cfg   = cfg_a5;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("post_rst_valid", {63'd0, valid}, 64'd1);
    check("post_rst_idx",   {61'd0, idx},   64'd0);
    check("post_rst_data",  {32'd0, data},  {32'd0, 32'hA5A5A5A5});
    for (int k = 0; k < 5; k++) tick();
    check("post_rst_done_pulse", {63'd0, done}, 64'd1);

`ifdef SAURIA_CFG_RB_PARITY_EN
    tick();
    start64 = 1'b1;
    ready64 = 1'b1;
    tick();
    start64 = 1'b0;
    check("par_w0_data", {32'd0, data64}, 64'd1);
    check("par_w0_par",  {63'd0, par64},  64'd1);
    check("par_w0_chk0", {32'd0, chk64},  64'd0);
    tick();
    check("par_w1_data", {32'd0, data64}, 64'd0);
    check("par_w1_par",  {63'd0, par64},  64'd0);
    check("par_w1_last", {63'd0, last64}, 64'd1);
    tick();
    check("par_done",    {63'd0, done64}, 64'd1);
    check("par_chk",     {32'd0, chk64},  64'd1);
    tick();
    check("par_chk_hold", {32'd0, chk64}, 64'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sauria_cfg_readback.md
Name: sauria_cfg_readback

Overview:
Transmit side of the SAURIA configuration-register interface.
- Takes a wide, packed configuration vector (the CON, ACT, WEI or OUT config structure).
- On request, streams it out as consecutive 32-bit words over a valid/ready port, LSB word first.
- Used for config readback to the host and for forwarding configuration across the CDC/AXI boundary.

Parameters:
- CFG_BITS, 150, width of the packed configuration vector (for example ACT_IDX_W + 2*OUT_IDX_W + TH_W + 2 for CON).
- WORD_W, 32, output word width; fixed at 32 for the register interface.
- N_WORDS, ceil(CFG_BITS/WORD_W), localparam; number of words emitted per transfer.
- IDX_W, max(1, $clog2(N_WORDS)), localparam; width of the word index.

Ports:
- i_clk  input  1  clock.
- i_rstn  input  1  asynchronous active-low reset.
- i_cfg  input  CFG_BITS  packed configuration vector; sampled only on an accepted start.
- i_start  input  1  request a transfer; 1-cycle pulse or level.
- o_busy  output  1  transfer in progress.
- o_data  output  WORD_W  current word.
- o_idx  output  IDX_W  index of the current word, 0..N_WORDS-1.
- o_valid  output  1  o_data and o_idx are valid.
- i_ready  input  1  sink accepts the word.
- o_last  output  1  current word is word N_WORDS-1; qualified by o_valid.
- o_done  output  1  single-cycle pulse after the last word is accepted.

Behaviour:
- Reset: one clock, async active-low reset. While i_rstn=0, all outputs are 0, the shadow register is 0 and the FSM is in IDLE.
- Reset asserted mid-transfer aborts immediately. No o_done is produced, and the block returns to IDLE with o_valid=0.
- FSM states: IDLE, SEND, DONE.
- IDLE:
  - When i_start=1, snapshot i_cfg into a CFG_BITS shadow register and clear the word counter.
  - Go to SEND. o_valid=1 and o_busy=1 on the next cycle, so start-to-first-valid latency is 1 cycle.
- SEND:
  - o_data = shadow[idx*32 +: 32].
  - Bits above CFG_BITS in the final word are driven 0 (zero padding).
  - o_last=1 when idx == N_WORDS-1.
- Handshake:
  - A word transfers when o_valid && i_ready.
  - On a transfer with idx < N_WORDS-1: idx increments and o_valid stays 1, giving back-to-back words.
  - On a transfer with the last word: o_valid drops next cycle and the FSM goes to DONE.
- Handshake stability:
  - While o_valid=1 && i_ready=0, o_data, o_idx and o_last hold stable.
  - o_valid never deasserts without a handshake.
- DONE:
  - o_done=1 for exactly one cycle; o_busy=0 in this cycle.
  - Return to IDLE.
  - An i_start seen in DONE is ignored; a start is only accepted in IDLE.
- Starts during a transfer: i_start in SEND is ignored. Changes on i_cfg during SEND do not affect emitted data, because the shadow register isolates them.
- Minimum transfer length: N_WORDS+2 cycles from start to o_done with i_ready held 1 (start cycle, N_WORDS data cycles, done cycle).
- N_WORDS=1: the first word has o_last=1, and the transfer completes after a single handshake.
- Counter: the index never exceeds N_WORDS-1, so no wrap-around occurs.
- Holding i_start=1 continuously: a new transfer begins on the cycle after DONE (IDLE accepts it), snapshotting the then-current i_cfg.

Optional Feature:
- Macro: SAURIA_CFG_RB_PARITY_EN.
- When defined:
  - Adds output o_parity (1 bit), the even parity (XOR-reduce) of o_data, registered alongside o_data so it is valid with o_valid.
  - Adds output o_chk (32 bits), the running XOR of all words transferred in the current transfer.
  - o_chk clears at an accepted start and is stable from the cycle o_done pulses until the next accepted start.
- When undefined: the ports and logic are absent, and the remaining behaviour is identical.

Test Plan:
- CFG_BITS=150, i_cfg = 150 bits of 0xA5 pattern, i_ready=1, pulse start:
  - 5 words appear on consecutive cycles, idx 0..4.
  - Word 4 = bits [149:128] zero-extended (upper 10 bits 0), with o_last=1 on word 4 only.
  - o_done pulses on cycle 7 after start.
- Backpressure: i_ready toggled 1,0,0,1,...
  - o_data and o_idx hold stable during every i_ready=0 cycle.
  - All 5 words are received in order with no duplicates or drops.
- Snapshot isolation: change i_cfg to all-ones one cycle after start. Emitted words still match the original pattern.
- Start while busy: a second i_start at word 2 is ignored. Exactly 5 words and one o_done are produced.
- Reset mid-transfer: deassert i_rstn at word 3 (async, mid-cycle).
  - o_valid, o_busy and o_data go to 0 immediately, with no o_done.
  - A new start after reset emits from idx 0.
- With SAURIA_CFG_RB_PARITY_EN, i_cfg = 64'h1 (CFG_BITS=64):
  - Word 0: o_parity=1. Word 1: o_parity=0.
  - o_chk = 32'h1 after o_done.
